// File: rtl/serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serializer_ctrl
// Description : Bring-up controller for a three-channel TMDS serializer path.
//               It synchronizes the clock-generator lock and waits for a run of
//               stable lock cycles. It then holds the OSERDES in reset, sends
//               control symbols for a training window, and finally passes the
//               encoder symbols through. Losing lock, a retrain request or reset
//               restarts the sequence.
// Ports       : i_clk          pixel clock (only clock)
//               i_rst          synchronous active-high reset
//               i_clk_lock     clock-generator lock (asynchronous to i_clk)
//               i_retrain      single-cycle request to restart training
//               i_data_1..3    TMDS symbols from the encoders
//               o_data_1..3    registered symbols to the serializers
//               o_rst_oserdes  serializer reset (high = hold in reset)
//               o_active       high only while passing data through
//               o_state        0=WAIT_LOCK 1=RESET 2=TRAIN 3=RUN
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_ctrl #(
    parameter int         LOCK_CYCLES  = 16,
    parameter int         RST_CYCLES   = 8,
    parameter int         TRAIN_CYCLES = 64,
    parameter logic [9:0] CTRL_SYM     = 10'b1101010100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_lock,
    input  logic       i_retrain,
    input  logic [9:0] i_data_1,
    input  logic [9:0] i_data_2,
    input  logic [9:0] i_data_3,
    output logic [9:0] o_data_1,
    output logic [9:0] o_data_2,
    output logic [9:0] o_data_3,
    output logic       o_rst_oserdes,
    output logic       o_active,
    output logic [1:0] o_state
);

    localparam int c_max_cycles =
        (LOCK_CYCLES > RST_CYCLES)
            ? ((LOCK_CYCLES > TRAIN_CYCLES) ? LOCK_CYCLES : TRAIN_CYCLES)
            : ((RST_CYCLES  > TRAIN_CYCLES) ? RST_CYCLES  : TRAIN_CYCLES);
    localparam int c_cnt_w = $clog2(c_max_cycles) + 1;

    localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'(LOCK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rst_last   = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_train_last = c_cnt_w'(TRAIN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RESET     = 2'd1,
        ST_TRAIN     = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic [9:0]           r_data_1;
    logic [9:0]           r_data_2;
    logic [9:0]           r_data_3;

    // ------------------------------------------------------------------
    // State, counter, synchronizer and output data registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_data_1    <= CTRL_SYM;
            r_data_2    <= CTRL_SYM;
            r_data_3    <= CTRL_SYM;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lock_meta <= i_clk_lock;
            r_lock_s    <= r_lock_meta;
            // One shared select keeps the three channels skew-free.
            if (r_state == ST_RUN) begin
                r_data_1 <= i_data_1;
                r_data_2 <= i_data_2;
                r_data_3 <= i_data_3;
            end else begin
                r_data_1 <= CTRL_SYM;
                r_data_2 <= CTRL_SYM;
                r_data_3 <= CTRL_SYM;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (!r_lock_s) begin
            // Lock loss wins over every other transition, and in
            // WAIT_LOCK it also restarts the stability count.
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (r_cnt == c_lock_last) begin
                        w_state_nxt = ST_RESET;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_RESET: begin
                    if (r_cnt == c_rst_last) begin
                        w_state_nxt = ST_TRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_TRAIN: begin
                    if (i_retrain) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_train_last) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end
                ST_RUN: begin
                    if (i_retrain) begin
                        w_state_nxt = ST_TRAIN;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Decoded from the state register alone so they cannot glitch on
    // input activity.
    assign o_rst_oserdes = (r_state == ST_WAIT_LOCK) || (r_state == ST_RESET);
    assign o_active      = (r_state == ST_RUN);
    assign o_state       = r_state;
    assign o_data_1      = r_data_1;
    assign o_data_2      = r_data_2;
    assign o_data_3      = r_data_3;

endmodule
`default_nettype wire

// File: tb/tb_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializer_ctrl
// Description : Self-checking bench for serializer_ctrl. A phase/dwell model
//               built from the bring-up rules predicts the state and outputs
//               every cycle. Directed scenarios are followed by a randomized
//               soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer_ctrl;

    localparam int         LOCK  = 16;
    localparam int         RSTC  = 8;
    localparam int         TRAIN = 64;
    localparam logic [9:0] CTRL  = 10'b1101010100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       retrain = 1'b0;
    logic [9:0] d1 = '0, d2 = '0, d3 = '0;
    logic [9:0] q1, q2, q3;
    logic       rst_oserdes, active;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no = 0;
    bit hold_d1 = 1'b0;

    // Reference model: phase 0..3 with a dwell time per phase.
    int         m_phase = 0;
    int         m_dwell = 0;
    bit         m_sync[2] = '{1'b0, 1'b0};
    logic [9:0] m_d1 = CTRL, m_d2 = CTRL, m_d3 = CTRL;
    int         dur[3] = '{LOCK, RSTC, TRAIN};

    serializer_ctrl #(
        .LOCK_CYCLES (LOCK),
        .RST_CYCLES  (RSTC),
        .TRAIN_CYCLES(TRAIN),
        .CTRL_SYM    (CTRL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_lock   (lock),
        .i_retrain    (retrain),
        .i_data_1     (d1),
        .i_data_2     (d2),
        .i_data_3     (d3),
        .o_data_1     (q1),
        .o_data_2     (q2),
        .o_data_3     (q3),
        .o_rst_oserdes(rst_oserdes),
        .o_active     (active),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // Applies the rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        bit ls;
        if (rst) begin
            m_phase = 0;
            m_dwell = 0;
            m_sync  = '{1'b0, 1'b0};
            m_d1 = CTRL; m_d2 = CTRL; m_d3 = CTRL;
            return;
        end
        ls = m_sync[1];
        m_d1 = (m_phase == 3) ? d1 : CTRL;
        m_d2 = (m_phase == 3) ? d2 : CTRL;
        m_d3 = (m_phase == 3) ? d3 : CTRL;
        if (!ls) begin
            m_phase = 0;
            m_dwell = 0;
        end else if (retrain && m_phase >= 2) begin
            m_phase = 2;
            m_dwell = 0;
        end else if (m_phase < 3) begin
            if (m_dwell + 1 == dur[m_phase]) begin
                m_phase = m_phase + 1;
                m_dwell = 0;
            end else begin
                m_dwell = m_dwell + 1;
            end
        end
        m_sync[1] = m_sync[0];
        m_sync[0] = lock;
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check("state",       10'(state),       10'(m_phase));
        check("rst_oserdes", 10'(rst_oserdes), (m_phase < 2) ? 10'd1 : 10'd0);
        check("active",      10'(active),      (m_phase == 3) ? 10'd1 : 10'd0);
        check("data_1",      q1, m_d1);
        check("data_2",      q2, m_d2);
        check("data_3",      q3, m_d3);
        if (!hold_d1) d1 = 10'($urandom);
        d2 = 10'($urandom);
        d3 = 10'($urandom);
        retrain = 1'b0;
    endtask

    task automatic wait_state(input int ph, input int budget, input string tag);
        int k;
        k = 0;
        while (m_phase != ph && k < budget) begin
            step();
            k++;
        end
        check(tag, 10'(state), 10'(ph));
    endtask

    initial begin
        int low_left;
        low_left = 0;

        // Reset dominates lock and retrain.
        hold_d1 = 1'b1;
        d1 = 10'h1A6;
        rst = 1'b1; lock = 1'b1; retrain = 1'b1;
        step();
        retrain = 1'b1;
        step();
        check("reset_state", 10'(state), 10'd0);
        check("reset_data",  q1, CTRL);

        // Bring-up with lock high from edge 1.
        rst = 1'b0;
        edge_no = 0;
        for (int i = 0; i < 95; i++) begin
            step();
            if (edge_no == 17) check("bringup_e17_state", 10'(state), 10'd0);
            if (edge_no == 18) check("bringup_e18_state", 10'(state), 10'd1);
            if (edge_no == 25) check("bringup_e25_rst",   10'(rst_oserdes), 10'd1);
            if (edge_no == 26) check("bringup_e26_state", 10'(state), 10'd2);
            if (edge_no == 26) check("bringup_e26_rst",   10'(rst_oserdes), 10'd0);
            if (edge_no == 89) check("bringup_e89_state", 10'(state), 10'd2);
            if (edge_no == 90) check("bringup_e90_state", 10'(state), 10'd3);
            if (edge_no == 90) check("bringup_e90_data",  q1, CTRL);
            if (edge_no == 91) check("bringup_e91_data",  q1, 10'h1A6);
        end
        hold_d1 = 1'b0;
        repeat (20) step();

        // Retrain pulse in RUN.
        retrain = 1'b1;
        step();
        check("retrain_state", 10'(state), 10'd2);
        repeat (63) step();
        check("retrain_rst_low", 10'(rst_oserdes), 10'd0);
        wait_state(3, 10, "retrain_rerun");

        // Lock loss in RUN for five cycles.
        lock = 1'b0;
        step(); step();
        check("lockloss_e2_state", 10'(state), 10'd3);
        step();
        check("lockloss_e3_state", 10'(state), 10'd0);
        check("lockloss_e3_rst",   10'(rst_oserdes), 10'd1);
        step();
        check("lockloss_e4_data",  q2, CTRL);
        step();
        lock = 1'b1;
        wait_state(3, 120, "lockloss_rerun");

        // Lock glitch in WAIT_LOCK at count 10.
        lock = 1'b0;
        repeat (4) step();
        lock = 1'b1;
        repeat (12) step();
        lock = 1'b0;
        repeat (3) step();
        lock = 1'b1;
        repeat (17) step();
        check("glitch_still_wait", 10'(state), 10'd0);
        wait_state(1, 10, "glitch_reset");

        // Lock loss coinciding with retrain in TRAIN.
        wait_state(2, 20, "sim_train");
        repeat (5) step();
        lock = 1'b0;
        step(); step();
        retrain = 1'b1;
        step();
        check("sim_lockloss_wins", 10'(state), 10'd0);
        lock = 1'b1;
        wait_state(3, 120, "sim_rerun");

        // Reset pulse mid-RUN.
        repeat (7) step();
        rst = 1'b1;
        retrain = 1'b1;
        step();
        check("rst_run_state",  10'(state), 10'd0);
        check("rst_run_active", 10'(active), 10'd0);
        check("rst_run_data3",  q3, CTRL);
        rst = 1'b0;
        repeat (89) step();
        check("rst_run_e89", 10'(state), 10'd2);
        step();
        check("rst_run_e90", 10'(state), 10'd3);

        // Randomized soak: lock dropouts, retrain pulses, rare resets.
        for (int i = 0; i < 1500; i++) begin
            if (low_left > 0) begin
                low_left--;
                lock = 1'b0;
            end else begin
                lock = 1'b1;
                if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 6);
            end
            retrain = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
